// File: rtl/wash_program_timer.sv
// wash_program_timer
// Wash-program sequencer and countdown timer. Holds the selected wash mode,
// walks the WASH/RINSE/(DRAIN)/SPIN phases on the 1 Hz tick and reports the
// total remaining seconds plus a completion flag to the controller.
//
// Optional build macro: WASH_DRAIN_EN inserts a 5 s DRAIN phase between
// RINSE and SPIN for every mode except spin-only.
module wash_program_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       power_light,
  input  logic [1:0] run_state,
  input  logic       model_choose,
  output logic [1:0] mode,
  output logic [2:0] phase,
  output logic [6:0] rest_time,
  output logic       finish
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_WASH  = 3'd1,
    PH_RINSE = 3'd2,
    PH_DRAIN = 3'd3,
    PH_SPIN  = 3'd4,
    PH_DONE  = 3'd5
  } phase_e;

`ifdef WASH_DRAIN_EN
  localparam logic [6:0] DRAIN_S = 7'd5;
`else
  localparam logic [6:0] DRAIN_S = 7'd0;
`endif

  // Duration in seconds of one phase of a given mode (0 = phase skipped).
  function automatic logic [6:0] phase_dur(input logic [1:0] m, input phase_e p);
    phase_dur = 7'd0;
    case (p)
      PH_WASH: begin
        case (m)
          2'd0:    phase_dur = 7'd30;
          2'd1:    phase_dur = 7'd15;
          2'd2:    phase_dur = 7'd45;
          default: phase_dur = 7'd0;
        endcase
      end
      PH_RINSE: begin
        case (m)
          2'd0:    phase_dur = 7'd20;
          2'd1:    phase_dur = 7'd10;
          2'd2:    phase_dur = 7'd30;
          default: phase_dur = 7'd0;
        endcase
      end
      PH_DRAIN: begin
        phase_dur = (m == 2'd3) ? 7'd0 : DRAIN_S;
      end
      PH_SPIN: begin
        case (m)
          2'd0:    phase_dur = 7'd10;
          2'd1:    phase_dur = 7'd5;
          2'd2:    phase_dur = 7'd20;
          default: phase_dur = 7'd15;
        endcase
      end
      default: phase_dur = 7'd0;
    endcase
  endfunction

  // Whole-program length of a mode; this is what rest_time shows while idle.
  function automatic logic [6:0] mode_total(input logic [1:0] m);
    mode_total = phase_dur(m, PH_WASH) + phase_dur(m, PH_RINSE)
               + phase_dur(m, PH_DRAIN) + phase_dur(m, PH_SPIN);
  endfunction

  // First phase after p with a nonzero duration; DONE once SPIN is behind us.
  // Starting from IDLE this yields the program's first real phase.
  function automatic phase_e next_phase(input logic [1:0] m, input phase_e p);
    phase_e cand;
    next_phase = PH_DONE;
    for (int i = 4; i >= 1; i--) begin
      cand = phase_e'(i[2:0]);
      if ((i > int'(p)) && (phase_dur(m, cand) != 7'd0)) begin
        next_phase = cand;
      end
    end
  endfunction

  logic [1:0] mode_q, mode_d;
  phase_e     phase_q, phase_d;
  logic [6:0] rest_time_q, rest_time_d;
  logic [6:0] phase_left_q, phase_left_d;
  logic       finish_q, finish_d;
  logic       key_q, key_d;

  logic       key_edge;
  logic       run_go;
  logic       run_idle;
  phase_e     step_phase;

  assign key_edge   = model_choose & ~key_q;
  assign run_go     = (run_state == 2'b01);
  assign run_idle   = (run_state == 2'b00) || (run_state == 2'b11);
  assign step_phase = next_phase(mode_q, phase_q);

  // Next-state logic: power-off beats abort, abort beats tick counting.
  always_comb begin
    mode_d       = mode_q;
    phase_d      = phase_q;
    rest_time_d  = rest_time_q;
    phase_left_d = phase_left_q;
    finish_d     = finish_q;
    // Key is always tracked so a key held through power-up gives no edge.
    key_d        = model_choose;

    if (!power_light) begin
      phase_d      = PH_IDLE;
      rest_time_d  = mode_total(mode_q);
      phase_left_d = 7'd0;
      finish_d     = 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          finish_d     = 1'b0;
          phase_left_d = 7'd0;
          if (run_go) begin
            // Start cycle: the tick of this cycle is deliberately not counted.
            phase_d      = step_phase;
            phase_left_d = phase_dur(mode_q, step_phase);
            rest_time_d  = mode_total(mode_q);
          end else if (run_idle) begin
            if (key_edge) begin
              mode_d = mode_q + 2'd1;
            end
            rest_time_d = mode_total(mode_d);
          end
        end

        PH_WASH, PH_RINSE, PH_DRAIN, PH_SPIN: begin
          if (run_idle) begin
            phase_d      = PH_IDLE;
            rest_time_d  = mode_total(mode_q);
            phase_left_d = 7'd0;
            finish_d     = 1'b0;
          end else if (run_go && tick_1hz) begin
            // phase_left and rest_time are never 0 here, so no underflow.
            rest_time_d = rest_time_q - 7'd1;
            if (phase_left_q == 7'd1) begin
              // SPIN's last second is also rest_time's last second.
              phase_d      = step_phase;
              phase_left_d = phase_dur(mode_q, step_phase);
              finish_d     = (step_phase == PH_DONE);
            end else begin
              phase_left_d = phase_left_q - 7'd1;
            end
          end
        end

        PH_DONE: begin
          if (run_idle) begin
            phase_d     = PH_IDLE;
            rest_time_d = mode_total(mode_q);
            finish_d    = 1'b0;
          end else begin
            rest_time_d = 7'd0;
            finish_d    = 1'b1;
          end
          phase_left_d = 7'd0;
        end

        default: begin
          // Unused encodings fall back to a clean idle state.
          phase_d      = PH_IDLE;
          rest_time_d  = mode_total(mode_q);
          phase_left_d = 7'd0;
          finish_d     = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q       <= 2'd0;
      phase_q      <= PH_IDLE;
      rest_time_q  <= mode_total(2'd0);
      phase_left_q <= 7'd0;
      finish_q     <= 1'b0;
      key_q        <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      phase_q      <= phase_d;
      rest_time_q  <= rest_time_d;
      phase_left_q <= phase_left_d;
      finish_q     <= finish_d;
      key_q        <= key_d;
    end
  end

  assign mode      = mode_q;
  assign phase     = phase_q;
  assign rest_time = rest_time_q;
  assign finish    = finish_q;

endmodule
